// File: rtl/vme_slave_resp.sv
// VME-style D16 slave responder: synchronises the bus strobes, decodes an A16 register
// block and answers read/write cycles with DTACK_B after a configurable wait.
module vme_slave_resp #(
    parameter logic [15:0] BASE_ADDR = 16'hC000,
    parameter int          NREG      = 4,
    parameter int          WAIT      = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    AS_B,
    input  logic                    DS_B,
    input  logic                    WRITE_B,
    input  logic [5:0]              AM,
    input  logic [15:0]             A,
    input  logic [15:0]             D_IN,
    output logic [15:0]             D_OUT,
    output logic                    D_OE,
    output logic                    DTACK_B,
    output logic                    WR_STB,
    output logic [$clog2(NREG)-1:0] WR_IDX,
    output logic [16*NREG-1:0]      REG_Q
);

    localparam int IDX_W = $clog2(NREG);

    generate
        if (NREG < 2 || NREG > 16 || (1 << IDX_W) != NREG) begin : g_bad_nreg
            $error("NREG must be a power of two in 2..16");
        end
        if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
            $error("WAIT must be in 0..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAITST,
        ACK,
        IGNORE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              as_meta;
    logic              ds_meta;
    logic              as_s;
    logic              ds_s;
    logic [3:0]        cnt;
    logic [3:0]        cnt_next;
    logic [15:1]       a_cap;
    logic [15:0]       d_cap;
    logic [5:0]        am_cap;
    logic              write_b_cap;
    logic              capture;
    logic              ack_entry;
    logic              hit;
    logic [IDX_W-1:0]  idx;
    logic [15:0]       regs [NREG];
    logic              unused_a0;

    // Byte lane select is meaningless on a D16-only slave.
    assign unused_a0 = A[0];

    // Two-flop synchronisers for the asynchronous strobes; idle level is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            as_meta <= 1'b1;
            ds_meta <= 1'b1;
            as_s    <= 1'b1;
            ds_s    <= 1'b1;
        end else begin
            as_meta <= AS_B;
            ds_meta <= DS_B;
            as_s    <= as_meta;
            ds_s    <= ds_meta;
        end
    end

    // Bus fields are sampled once, when the synchronised strobes first show a cycle.
    always_ff @(posedge CLK) begin
        if (!RST && capture) begin
            a_cap       <= A[15:1];
            am_cap      <= AM;
            write_b_cap <= WRITE_B;
            d_cap       <= D_IN;
        end
    end

    assign hit = ((am_cap == 6'h29) || (am_cap == 6'h2D)) &&
                 (a_cap[15:IDX_W+1] == BASE_ADDR[15:IDX_W+1]);
    assign idx = a_cap[IDX_W:1];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (!as_s && !ds_s) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (!hit) begin
                    state_next = IGNORE;
                end else if (WAIT == 0) begin
                    state_next = ACK;
                end else begin
                    state_next = WAITST;
                    cnt_next   = 4'(WAIT - 1);
                end
            end
            WAITST: begin
                // Master gave up before we acknowledged: drop the cycle entirely.
                if (as_s || ds_s) begin
                    state_next = IDLE;
                end else if (cnt == 4'd0) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ACK: begin
                if (ds_s) begin
                    state_next = IDLE;
                end
            end
            IGNORE: begin
                if (as_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign capture   = (state == IDLE) && (state_next == DECODE);
    assign ack_entry = (state != ACK) && (state_next == ACK);

    // The register access happens on ACK entry so data is settled one edge before DTACK_B.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            DTACK_B <= 1'b1;
            D_OE    <= 1'b0;
            D_OUT   <= 16'h0000;
            WR_STB  <= 1'b0;
            WR_IDX  <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 16'h0000;
            end
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            DTACK_B <= !((state == ACK) && !ds_s);
            D_OE    <= (state == ACK) && !ds_s && write_b_cap;
            WR_STB  <= ack_entry && !write_b_cap;
            if (ack_entry) begin
                if (write_b_cap) begin
                    D_OUT <= regs[idx];
                end else begin
                    regs[idx] <= d_cap;
                    WR_IDX    <= idx;
                end
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_reg_q
        assign REG_Q[16*g +: 16] = regs[g];
    end

endmodule

// File: tb/tb_vme_slave_resp.sv
// Scoreboard bench for vme_slave_resp: directed bus cycles push expected acknowledges,
// a negedge monitor pops and compares them whenever DTACK_B falls or WR_STB pulses.
module tb_vme_slave_resp;

    localparam int WAIT_T = 2;

    typedef struct {
        logic        is_read;
        logic [1:0]  idx;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        as_b;
    logic        ds_b;
    logic        write_b;
    logic [5:0]  am;
    logic [15:0] a;
    logic [15:0] d_in;
    logic [15:0] d_out;
    logic        d_oe;
    logic        dtack_b;
    logic        wr_stb;
    logic [1:0]  wr_idx;
    logic [63:0] reg_q;

    logic        as8_b;
    logic        ds8_b;
    logic [15:0] d_out8;
    logic        d_oe8;
    logic        dtack8_b;
    logic        wr_stb8;
    logic [1:0]  wr_idx8;
    logic [63:0] reg_q8;

    exp_t        ack_q[$];
    exp_t        wr_q[$];
    logic [15:0] model [4];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr8_cnt  = 0;
    logic        prev_dtack = 1'b1;

    vme_slave_resp #(.BASE_ADDR(16'hC000), .NREG(4), .WAIT(WAIT_T)) u_dut (
        .CLK(clk), .RST(rst), .AS_B(as_b), .DS_B(ds_b), .WRITE_B(write_b), .AM(am),
        .A(a), .D_IN(d_in), .D_OUT(d_out), .D_OE(d_oe), .DTACK_B(dtack_b),
        .WR_STB(wr_stb), .WR_IDX(wr_idx), .REG_Q(reg_q)
    );

    vme_slave_resp #(.BASE_ADDR(16'hC000), .NREG(4), .WAIT(8)) u_dut8 (
        .CLK(clk), .RST(rst), .AS_B(as8_b), .DS_B(ds8_b), .WRITE_B(write_b), .AM(am),
        .A(a), .D_IN(d_in), .D_OUT(d_out8), .D_OE(d_oe8), .DTACK_B(dtack8_b),
        .WR_STB(wr_stb8), .WR_IDX(wr_idx8), .REG_Q(reg_q8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    // Monitor: compares every acknowledge and write strobe against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (wr_stb === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("wr_stb_unexpected", {63'd0, wr_stb}, 64'd0);
            end else begin
                e = wr_q.pop_front();
                chk("wr_idx", {62'd0, wr_idx}, {62'd0, e.idx});
                chk("wr_data", {48'd0, reg_q[16*e.idx +: 16]}, {48'd0, e.data});
            end
        end
        if (prev_dtack === 1'b1 && dtack_b === 1'b0) begin
            if (ack_q.size() == 0) begin
                chk("dtack_unexpected", {63'd0, dtack_b}, 64'd1);
            end else begin
                e = ack_q.pop_front();
                chk("ack_d_oe", {63'd0, d_oe}, {63'd0, e.is_read});
                if (e.is_read) begin
                    chk("ack_d_out", {48'd0, d_out}, {48'd0, e.data});
                end else begin
                    chk("ack_reg", {48'd0, reg_q[16*e.idx +: 16]}, {48'd0, e.data});
                end
            end
        end
        if (wr_stb8 === 1'b1) begin
            wr8_cnt <= wr8_cnt + 1;
        end
        prev_dtack <= dtack_b;
    end

    task automatic bus_cycle(input logic wr_b, input logic [5:0] am_v, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic hit, input logic keep_as,
                             input string tag);
        exp_t e;
        write_b = wr_b;
        am      = am_v;
        a       = addr;
        d_in    = wdata;
        as_b    = 1'b0;
        ds_b    = 1'b0;
        if (hit) begin
            e.is_read = wr_b;
            e.idx     = addr[2:1];
            e.data    = wr_b ? model[addr[2:1]] : wdata;
            ack_q.push_back(e);
            if (!wr_b) begin
                wr_q.push_back(e);
                model[addr[2:1]] = wdata;
            end
        end
        for (int i = 0; i <= 4 + WAIT_T; i++) begin
            tick();
            if (i == 3 + WAIT_T) chk({tag, "_dtack_pre"}, {63'd0, dtack_b}, 64'd1);
        end
        chk({tag, "_dtack_ack"}, {63'd0, dtack_b}, hit ? 64'd0 : 64'd1);
        tick();
        tick();
        ds_b = 1'b1;
        if (!keep_as) as_b = 1'b1;
        tick();
        tick();
        chk({tag, "_dtack_hold"}, {63'd0, dtack_b}, hit ? 64'd0 : 64'd1);
        tick();
        chk({tag, "_dtack_rel"}, {63'd0, dtack_b}, 64'd1);
        chk({tag, "_d_oe_rel"}, {63'd0, d_oe}, 64'd0);
        chk({tag, "_regs"}, reg_q, model_flat());
        tick();
    endtask

    initial begin
        exp_t e;
        int   lows;
        rst = 1'b1; as_b = 1'b1; ds_b = 1'b1; as8_b = 1'b1; ds8_b = 1'b1;
        write_b = 1'b1; am = 6'h00; a = 16'h0000; d_in = 16'h0000;
        for (int i = 0; i < 4; i++) model[i] = 16'h0000;

        // Reset state
        tick();
        tick();
        chk("rst_dtack", {63'd0, dtack_b}, 64'd1);
        chk("rst_d_oe", {63'd0, d_oe}, 64'd0);
        chk("rst_reg_q", reg_q, 64'd0);
        chk("rst_wr_stb", {63'd0, wr_stb}, 64'd0);
        chk("rst_d_out", {48'd0, d_out}, 64'd0);
        chk("rst_wr_idx", {62'd0, wr_idx}, 64'd0);
        chk("rst_dtack8", {63'd0, dtack8_b}, 64'd1);
        rst = 1'b0;
        tick();

        // Write, read back, re-strobe with AS held, other AM, reads of other registers
        bus_cycle(1'b0, 6'h29, 16'hC004, 16'hA5A5, 1'b1, 1'b0, "wr_c004");
        chk("reg2_a5a5", {48'd0, reg_q[47:32]}, 64'h0000_0000_0000_A5A5);
        bus_cycle(1'b1, 6'h29, 16'hC004, 16'h0000, 1'b1, 1'b0, "rd_c004");
        chk("d_out_hold", {48'd0, d_out}, 64'h0000_0000_0000_A5A5);
        bus_cycle(1'b0, 6'h29, 16'hC002, 16'h1111, 1'b1, 1'b1, "wr_c002");
        bus_cycle(1'b0, 6'h29, 16'hC006, 16'h2222, 1'b1, 1'b0, "wr_c006_restrobe");
        bus_cycle(1'b1, 6'h2D, 16'hC006, 16'h0000, 1'b1, 1'b0, "rd_c006_am2d");
        bus_cycle(1'b1, 6'h29, 16'hC000, 16'h0000, 1'b1, 1'b0, "rd_c000");
        chk("d_out_zero_reg0", {48'd0, d_out}, 64'd0);

        // Misses: wrong address, wrong AM, first address past the block
        bus_cycle(1'b0, 6'h29, 16'hD000, 16'hDEAD, 1'b0, 1'b0, "miss_addr");
        bus_cycle(1'b0, 6'h39, 16'hC004, 16'hBEEF, 1'b0, 1'b0, "miss_am");
        bus_cycle(1'b1, 6'h29, 16'hC008, 16'h0000, 1'b0, 1'b0, "miss_c008");

        // Abort during the wait states of the WAIT=8 instance
        write_b = 1'b0; am = 6'h29; a = 16'hC002; d_in = 16'h1234;
        as8_b = 1'b0; ds8_b = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("abort_dtack_mid", {63'd0, dtack8_b}, 64'd1);
        ds8_b = 1'b1;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dtack8_b !== 1'b1) lows++;
        end
        chk("abort_dtack_low_samples", lows, 64'd0);
        chk("abort_wr_stb_count", wr8_cnt, 64'd0);
        chk("abort_reg_q8", reg_q8, 64'd0);
        as8_b = 1'b1;
        tick();
        tick();
        d_in = 16'h5A5A;
        as8_b = 1'b0; ds8_b = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            tick();
            if (i == 11) chk("w8_dtack_pre", {63'd0, dtack8_b}, 64'd1);
        end
        chk("w8_dtack_ack", {63'd0, dtack8_b}, 64'd0);
        chk("w8_wr_stb_count", wr8_cnt, 64'd1);
        chk("w8_wr_idx", {62'd0, wr_idx8}, 64'd1);
        chk("w8_reg_q", reg_q8, 64'h0000_0000_5A5A_0000);
        as8_b = 1'b1; ds8_b = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("w8_dtack_rel", {63'd0, dtack8_b}, 64'd1);
        chk("w8_d_oe", {63'd0, d_oe8}, 64'd0);
        chk("w8_d_out", {48'd0, d_out8}, 64'd0);

        // Reset while acknowledging a read; held strobes start a fresh cycle
        write_b = 1'b1; am = 6'h29; a = 16'hC004; d_in = 16'h0000;
        e.is_read = 1'b1; e.idx = 2'd2; e.data = model[2];
        ack_q.push_back(e);
        as_b = 1'b0; ds_b = 1'b0;
        for (int i = 0; i <= 6; i++) tick();
        chk("rack_dtack_before", {63'd0, dtack_b}, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rack_dtack", {63'd0, dtack_b}, 64'd1);
        chk("rack_d_oe", {63'd0, d_oe}, 64'd0);
        chk("rack_reg_q", reg_q, 64'd0);
        chk("rack_d_out", {48'd0, d_out}, 64'd0);
        chk("rack_wr_stb", {63'd0, wr_stb}, 64'd0);
        for (int i = 0; i < 4; i++) model[i] = 16'h0000;
        e.is_read = 1'b1; e.idx = 2'd2; e.data = 16'h0000;
        ack_q.push_back(e);
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6) chk("fresh_dtack_pre", {63'd0, dtack_b}, 64'd1);
        end
        chk("fresh_dtack_ack", {63'd0, dtack_b}, 64'd0);
        chk("fresh_d_oe", {63'd0, d_oe}, 64'd1);
        as_b = 1'b1; ds_b = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("fresh_dtack_rel", {63'd0, dtack_b}, 64'd1);
        chk("fresh_reg_q", reg_q, 64'd0);

        tick();
        chk("ack_q_drained", ack_q.size(), 64'd0);
        chk("wr_q_drained", wr_q.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
